// File: rtl/instruction_fetch_pkg.sv
// Shared definitions for the fetch/decode slice: FSM states, opcodes, ALU codes.
package instruction_fetch_pkg;

   localparam logic [31:0] ResetPcDefault = 32'h0000_0000;

   typedef enum logic [1:0] {
      StIdle  = 2'd0,
      StReq   = 2'd1,
      StIssue = 2'd2
   } fetch_state_e;

   localparam logic [5:0] OpLw   = 6'h23;
   localparam logic [5:0] OpSw   = 6'h2b;
   localparam logic [5:0] OpJ    = 6'h02;
   localparam logic [5:0] OpJal  = 6'h03;
   localparam logic [5:0] OpBeq  = 6'h04;
   localparam logic [5:0] OpBne  = 6'h05;
   localparam logic [5:0] OpXori = 6'h0e;
   localparam logic [5:0] OpAddi = 6'h08;

   typedef enum logic [2:0] {
      AluAdd = 3'd0,
      AluSub = 3'd1,
      AluAnd = 3'd2,
      AluOr  = 3'd3,
      AluXor = 3'd4,
      AluSlt = 3'd5
   } alu_op_e;

endpackage

// File: rtl/instruction_fetch_next_pc_calc.sv
// Combinational next-PC selection: register jump, absolute jump, taken branch, sequential.
module next_pc_calc #(
   parameter int unsigned ADDR_W = 32
) (
   input  logic [ADDR_W-1:0] pc_plus4_i,
   input  logic [25:0]       instr_idx_i,
   input  logic              jump_i,
   input  logic              jump_link_i,
   input  logic              jump_reg_i,
   input  logic              branch_e_i,
   input  logic              branch_ne_i,
   input  logic              alu_zero_i,
   input  logic [ADDR_W-1:0] jr_target_i,
   output logic [ADDR_W-1:0] next_pc_o
);

   logic              br_taken;
   logic [ADDR_W-1:0] br_off;
   logic [ADDR_W-1:0] jmp_tgt;

   always_comb begin
      // Both branch flavours asserted together collapse to "always taken".
      br_taken = (branch_e_i & alu_zero_i) | (branch_ne_i & ~alu_zero_i);
      br_off   = {{(ADDR_W-18){instr_idx_i[15]}}, instr_idx_i[15:0], 2'b00};
      jmp_tgt  = {pc_plus4_i[ADDR_W-1:28], instr_idx_i, 2'b00};

      if (jump_reg_i) begin
         next_pc_o = {jr_target_i[ADDR_W-1:2], 2'b00};
      end else if (jump_i || jump_link_i) begin
         next_pc_o = jmp_tgt;
      end else if (br_taken) begin
         next_pc_o = pc_plus4_i + br_off;
      end else begin
         next_pc_o = pc_plus4_i;
      end
   end

endmodule

// File: rtl/instruction_fetch.sv
// Single-outstanding instruction fetch unit: request, capture, hold until decode accepts.
module instruction_fetch
   import instruction_fetch_pkg::*;
#(
   parameter logic [31:0] RESET_PC = ResetPcDefault,
   parameter int unsigned ADDR_W   = 32
) (
   input  logic              clk,
   input  logic              rst_n,
   output logic              imem_req_o,
   output logic [ADDR_W-1:0] imem_addr_o,
   input  logic              imem_ack_i,
   input  logic [31:0]       imem_rdata_i,
   output logic [31:0]       instr_o,
   output logic [5:0]        op_o,
   output logic              instr_valid_o,
   input  logic              instr_ready_i,
   output logic [ADDR_W-1:0] pc_plus4_o,
   input  logic              jump_i,
   input  logic              jump_link_i,
   input  logic              jump_reg_i,
   input  logic              branch_e_i,
   input  logic              branch_ne_i,
   input  logic              alu_zero_i,
   input  logic [ADDR_W-1:0] jr_target_i,
   output logic              pc_misalign_o
);

   localparam logic [ADDR_W-1:0] ResetPc = RESET_PC[ADDR_W-1:0];
   localparam logic [ADDR_W-1:0] PcStep  = ADDR_W'(4);

   fetch_state_e      state_q, state_d;
   logic [ADDR_W-1:0] pc_q, pc_d;
   logic [31:0]       instr_q, instr_d;
   logic              misalign_q, misalign_d;
   logic [ADDR_W-1:0] pc_plus4;
   logic [ADDR_W-1:0] next_pc;
   logic              handshake;
   logic              capture;

   assign pc_plus4  = pc_q + PcStep;
   assign handshake = (state_q == StIssue) & instr_ready_i;
   assign capture   = (state_q == StReq) & imem_ack_i;

   next_pc_calc #(
      .ADDR_W(ADDR_W)
   ) u_next_pc_calc (
      .pc_plus4_i  (pc_plus4),
      .instr_idx_i (instr_q[25:0]),
      .jump_i      (jump_i),
      .jump_link_i (jump_link_i),
      .jump_reg_i  (jump_reg_i),
      .branch_e_i  (branch_e_i),
      .branch_ne_i (branch_ne_i),
      .alu_zero_i  (alu_zero_i),
      .jr_target_i (jr_target_i),
      .next_pc_o   (next_pc)
   );

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q <= StIdle;
      end else begin
         state_q <= state_d;
      end
   end

   always_comb begin
      state_d = state_q;
      unique case (state_q)
         StIdle:  state_d = StReq;
         StReq:   if (imem_ack_i) state_d = StIssue;
         StIssue: if (instr_ready_i) state_d = StReq;
         default: state_d = StIdle;
      endcase
   end

   always_comb begin
      imem_req_o    = (state_q == StReq);
      instr_valid_o = (state_q == StIssue);
   end

   // Redirect inputs only matter on the handshake edge; otherwise the PC holds.
   always_comb begin
      pc_d       = handshake ? next_pc : pc_q;
      instr_d    = capture ? imem_rdata_i : instr_q;
      misalign_d = handshake & jump_reg_i & (|jr_target_i[1:0]);
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         pc_q       <= ResetPc;
         instr_q    <= '0;
         misalign_q <= 1'b0;
      end else begin
         pc_q       <= pc_d;
         instr_q    <= instr_d;
         misalign_q <= misalign_d;
      end
   end

   assign imem_addr_o   = pc_q;
   assign instr_o       = instr_q;
   assign op_o          = instr_q[31:26];
   assign pc_plus4_o    = pc_plus4;
   assign pc_misalign_o = misalign_q;

endmodule

// File: tb/tb_instruction_fetch.sv
// Randomized + directed bench for instruction_fetch against a transaction-level model.
module tb_instruction_fetch;
   import instruction_fetch_pkg::*;

   logic        clk = 1'b0;
   logic        rst_n = 1'b0;
   logic        imem_req_o;
   logic [31:0] imem_addr_o;
   logic        imem_ack_i = 1'b0;
   logic [31:0] imem_rdata_i = '0;
   logic [31:0] instr_o;
   logic [5:0]  op_o;
   logic        instr_valid_o;
   logic        instr_ready_i = 1'b0;
   logic [31:0] pc_plus4_o;
   logic        jump_i = 1'b0, jump_link_i = 1'b0, jump_reg_i = 1'b0;
   logic        branch_e_i = 1'b0, branch_ne_i = 1'b0, alu_zero_i = 1'b0;
   logic [31:0] jr_target_i = '0;
   logic        pc_misalign_o;

   int total = 0;
   int bad   = 0;
   bit chk_en = 1'b0;

   instruction_fetch #(
      .RESET_PC(32'h0000_0000),
      .ADDR_W  (32)
   ) dut (
      .clk          (clk),
      .rst_n        (rst_n),
      .imem_req_o   (imem_req_o),
      .imem_addr_o  (imem_addr_o),
      .imem_ack_i   (imem_ack_i),
      .imem_rdata_i (imem_rdata_i),
      .instr_o      (instr_o),
      .op_o         (op_o),
      .instr_valid_o(instr_valid_o),
      .instr_ready_i(instr_ready_i),
      .pc_plus4_o   (pc_plus4_o),
      .jump_i       (jump_i),
      .jump_link_i  (jump_link_i),
      .jump_reg_i   (jump_reg_i),
      .branch_e_i   (branch_e_i),
      .branch_ne_i  (branch_ne_i),
      .alu_zero_i   (alu_zero_i),
      .jr_target_i  (jr_target_i),
      .pc_misalign_o(pc_misalign_o)
   );

   always #5 clk = ~clk;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s: got %h want %h (t=%0t)", name, act, exp, $time);
      end
   endtask

   // Model: 0 = waiting one cycle after reset, 1 = fetching, 2 = holding an instruction.
   int          m_phase = 0;
   logic [31:0] m_pc    = 32'h0;
   logic [31:0] m_instr = 32'h0;
   bit          m_mis   = 1'b0;

   function automatic logic [31:0] ref_next(input logic [31:0] pc, input logic [31:0] ins,
                                            input bit jr, input bit j, input bit jl,
                                            input bit be, input bit bne, input bit z,
                                            input logic [31:0] jt);
      logic [31:0] seq;
      int          imm;
      seq = pc + 32'd4;
      imm = int'($signed(ins[15:0]));
      if (jr) return jt & 32'hFFFF_FFFC;
      if (j || jl) return (seq & 32'hF000_0000) | ({6'b0, ins[25:0]} * 32'd4);
      if ((be && z) || (bne && !z)) return seq + 32'(imm * 4);
      return seq;
   endfunction

   always @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         m_phase <= 0;
         m_pc    <= 32'h0;
         m_instr <= 32'h0;
         m_mis   <= 1'b0;
      end else begin
         m_mis <= 1'b0;
         case (m_phase)
            0: m_phase <= 1;
            1: if (imem_ack_i) begin
                  m_instr <= imem_rdata_i;
                  m_phase <= 2;
               end
            default: if (instr_ready_i) begin
                  m_pc    <= ref_next(m_pc, m_instr, jump_reg_i, jump_i, jump_link_i,
                                      branch_e_i, branch_ne_i, alu_zero_i, jr_target_i);
                  m_mis   <= jump_reg_i && (jr_target_i[1:0] != 2'b00);
                  m_phase <= 1;
               end
         endcase
      end
   end

   always @(negedge clk) begin
      if (chk_en) begin
         chk("m_req",      32'(imem_req_o),    32'(m_phase == 1));
         chk("m_addr",     imem_addr_o,        m_pc);
         chk("m_valid",    32'(instr_valid_o), 32'(m_phase == 2));
         chk("m_instr",    instr_o,            m_instr);
         chk("m_op",       32'(op_o),          32'(m_instr[31:26]));
         chk("m_pcplus4",  pc_plus4_o,         m_pc + 32'd4);
         chk("m_misalign", 32'(pc_misalign_o), 32'(m_mis));
      end
   end

   task automatic step();
      @(negedge clk);
   endtask

   task automatic clear_ctl();
      jump_i = 0; jump_link_i = 0; jump_reg_i = 0;
      branch_e_i = 0; branch_ne_i = 0; alu_zero_i = 0; instr_ready_i = 0;
   endtask

   task automatic do_reset();
      @(negedge clk);
      #2 rst_n = 1'b0;
      imem_ack_i = 0;
      clear_ctl();
      step();
      step();
      rst_n = 1'b1;
   endtask

   task automatic wait_req();
      int n = 0;
      while (!imem_req_o && n < 50) begin
         step();
         n++;
      end
      if (!imem_req_o) chk("req_timeout", 32'(imem_req_o), 32'd1);
   endtask

   task automatic fetch(input logic [31:0] w, input int dly);
      wait_req();
      repeat (dly) step();
      imem_ack_i   = 1'b1;
      imem_rdata_i = w;
      step();
      imem_ack_i   = 1'b0;
      imem_rdata_i = $urandom;
   endtask

   task automatic issue(input bit jr, input bit j, input bit jl, input bit be, input bit bne,
                        input bit z, input logic [31:0] jt);
      chk("issue_valid", 32'(instr_valid_o), 32'd1);
      jump_reg_i = jr; jump_i = j; jump_link_i = jl;
      branch_e_i = be; branch_ne_i = bne; alu_zero_i = z;
      jr_target_i = jt; instr_ready_i = 1'b1;
      step();
      clear_ctl();
   endtask

   task automatic goto_pc(input logic [31:0] a);
      fetch(32'h0, 0);
      issue(1, 0, 0, 0, 0, 0, a);
   endtask

   initial begin
      logic [31:0] held;
      do_reset();
      chk_en = 1'b1;
      // Reset values while still in IDLE
      chk("rst_req",   32'(imem_req_o),    32'd0);
      chk("rst_addr",  imem_addr_o,        32'h0);
      chk("rst_valid", 32'(instr_valid_o), 32'd0);
      chk("rst_p4",    pc_plus4_o,         32'h4);

      // First fetch, ack after two REQ cycles
      step();
      chk("f0_req",  32'(imem_req_o), 32'd1);
      chk("f0_addr", imem_addr_o,     32'h0);
      repeat (2) step();
      imem_ack_i = 1; imem_rdata_i = 32'h2008_0005;
      step();
      imem_ack_i = 0;
      chk("f0_valid", 32'(instr_valid_o), 32'd1);
      chk("f0_op",    32'(op_o),          32'(OpAddi));
      chk("f0_p4",    pc_plus4_o,         32'h4);
      chk("f0_req_off", 32'(imem_req_o),  32'd0);

      // Stall: instruction holds, no request
      held = instr_o;
      repeat (5) begin
         step();
         chk("stall_instr", instr_o,         held);
         chk("stall_req",   32'(imem_req_o), 32'd0);
      end
      issue(0, 0, 0, 0, 0, 0, 32'h0);
      chk("seq_addr", imem_addr_o, 32'h4);

      // Branch back and forward from 0x40
      goto_pc(32'h40);
      fetch({OpBeq, 10'd0, 16'hFFFE}, 1);
      issue(0, 0, 0, 1, 0, 1, 32'h0);
      chk("beq_taken", imem_addr_o, 32'h3C);
      goto_pc(32'h40);
      fetch({OpBeq, 10'd0, 16'hFFFE}, 0);
      issue(0, 0, 0, 1, 0, 0, 32'h0);
      chk("beq_not", imem_addr_o, 32'h44);
      goto_pc(32'h40);
      fetch({OpBne, 10'd0, 16'h0003}, 0);
      issue(0, 0, 0, 1, 1, 0, 32'h0);
      chk("both_br", imem_addr_o, 32'h50);

      // Absolute jumps
      goto_pc(32'h1000_0000);
      fetch({OpJ, 26'h000_0010}, 0);
      issue(0, 1, 0, 0, 0, 0, 32'h0);
      chk("j_tgt", imem_addr_o, 32'h1000_0040);
      goto_pc(32'h1000_0000);
      fetch({OpJal, 26'h000_0010}, 2);
      chk("jal_p4", pc_plus4_o, 32'h1000_0004);
      issue(0, 0, 1, 0, 0, 0, 32'h0);
      chk("jal_tgt", imem_addr_o, 32'h1000_0040);

      // Misaligned register jump
      fetch(32'h0, 0);
      issue(1, 0, 0, 0, 0, 0, 32'h0000_0103);
      chk("jr_addr", imem_addr_o,         32'h100);
      chk("jr_mis",  32'(pc_misalign_o),  32'd1);
      step();
      chk("jr_mis_off", 32'(pc_misalign_o), 32'd0);

      // Wraparound
      goto_pc(32'hFFFF_FFFC);
      fetch(32'h1234_5678, 0);
      issue(0, 0, 0, 0, 0, 0, 32'h0);
      chk("wrap", imem_addr_o, 32'h0);

      // Reset mid-fetch with an ack landing during and just after reset
      wait_req();
      #2 rst_n = 1'b0;
      #1;
      chk("r42_req",   32'(imem_req_o),    32'd0);
      chk("r42_instr", instr_o,            32'h0);
      chk("r42_addr",  imem_addr_o,        32'h0);
      imem_ack_i = 1; imem_rdata_i = 32'hDEAD_BEEF;
      step();
      step();
      rst_n = 1'b1;
      step();
      imem_ack_i = 0;
      chk("r42_req2",  32'(imem_req_o),    32'd1);
      chk("r42_addr2", imem_addr_o,        32'h0);
      chk("r42_valid", 32'(instr_valid_o), 32'd0);

      // Randomized traffic
      for (int i = 0; i < 4000; i++) begin
         if ($urandom_range(0, 499) == 0) begin
            do_reset();
         end else begin
            imem_ack_i    = ($urandom_range(0, 2) == 0);
            imem_rdata_i  = $urandom;
            instr_ready_i = $urandom_range(0, 1) == 1;
            jump_reg_i    = $urandom_range(0, 7) == 0;
            jump_i        = $urandom_range(0, 7) == 0;
            jump_link_i   = $urandom_range(0, 7) == 0;
            branch_e_i    = $urandom_range(0, 3) == 0;
            branch_ne_i   = $urandom_range(0, 3) == 0;
            alu_zero_i    = $urandom_range(0, 1) == 1;
            jr_target_i   = $urandom;
            step();
         end
      end

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule

// File: doc/instruction_fetch.md
INSTRUCTION_FETCH -- requirements
Module: instruction_fetch

Interface
REQ-001 Parameter RESET_PC, default 32'h0000_0000: first fetch address after reset.
REQ-002 Parameter ADDR_W, default 32: width of all PC/address signals.
REQ-003 clk  input  1  single clock; all state on rising edge.
REQ-004 rst_n  input  1  asynchronous, active-low reset.
REQ-005 imem_req  output  1  fetch request to instruction memory.
REQ-006 imem_addr  output  ADDR_W  word-aligned fetch address.
REQ-007 imem_ack  input  1  memory response valid; imem_rdata valid same cycle.
REQ-008 imem_rdata  input  32  fetched instruction word.
REQ-009 instr  output  32  instruction presented to decode.
REQ-010 op  output  6  instr[31:26], opcode field for decode.
REQ-011 instr_valid  output  1  instr/op/pc_plus4 valid.
REQ-012 instr_ready  input  1  decode accepts instr this cycle.
REQ-013 pc_plus4  output  ADDR_W  address of issued instruction + 4 (JAL link value).
REQ-014 jump, jumpLink, jumpReg, branchE, branchNE  input  1 each  decode controls for the issued instruction.
REQ-015 alu_zero  input  1  ALU zero flag for the issued instruction.
REQ-016 jr_target  input  ADDR_W  register value for jumpReg.
REQ-017 pc_misalign  output  1  one-cycle pulse: jr_target[1:0] nonzero.

Function
REQ-018 FSM states: IDLE, REQ, ISSUE; IDLE entered on reset only.
REQ-019 IDLE -> REQ unconditionally on first clk edge after reset release.
REQ-020 REQ: imem_req=1, imem_addr=pc; on imem_ack capture imem_rdata into instr, go to ISSUE.
REQ-021 imem_ack in the first REQ cycle is accepted; ack outside REQ is ignored.
REQ-022 Fetch latency: instr_valid rises the cycle after imem_ack.
REQ-023 ISSUE: instr_valid=1; instr, op, pc_plus4 held stable until instr_ready.
REQ-024 Handshake completes on instr_valid & instr_ready; same edge loads pc=next_pc and enters REQ.
REQ-025 Redirect controls and alu_zero sampled only on the handshake cycle.
REQ-026 next_pc priority: jumpReg -> {jr_target[ADDR_W-1:2],2'b00}; else jump or jumpLink -> {pc_plus4[31:28], instr[25:0], 2'b00}; else (branchE & alu_zero) or (branchNE & ~alu_zero) -> pc_plus4 + (sign-extended instr[15:0] << 2); else pc_plus4.
REQ-027 branchE and branchNE both high: taken regardless of alu_zero.
REQ-028 All address arithmetic modulo 2^ADDR_W; 32'hFFFF_FFFC + 4 wraps to 0.
REQ-029 pc_misalign pulses the cycle after a handshake with jumpReg=1 and jr_target[1:0]!=0; fetch proceeds at the aligned address.
REQ-030 imem_req is 0 in IDLE and ISSUE; at most one outstanding fetch.

Reset
REQ-031 rst_n low asynchronously forces: state=IDLE, pc=RESET_PC, imem_req=0, imem_addr=RESET_PC, instr=0, op=0, instr_valid=0, pc_plus4=RESET_PC+4, pc_misalign=0.
REQ-032 Reset mid-fetch discards the outstanding request; a late imem_ack after reset release before REQ is ignored.
REQ-033 Reset during ISSUE drops the instruction; no handshake occurs.

Structure
REQ-034 Shared package holds: FSM state enum, opcode constants (LW, SW, J, JAL, BEQ, BNE, XORI, ADDI), ALU operation codes, RESET_PC default.
REQ-035 One sub-module next_pc_calc: purely combinational implementation of REQ-026/028.
REQ-036 Opcode constants in the package are the sole definition used by both fetch and decode.

Verification
REQ-037 Reset release, imem_ack after 2 cycles with 32'h2008_0005 -> imem_addr=0, instr_valid next cycle, op=6'b001000, pc_plus4=4.
REQ-038 Issue at pc=0x40 with BEQ imm=16'hFFFE, alu_zero=1, instr_ready=1 -> next imem_addr=0x3C; alu_zero=0 -> 0x44.
REQ-039 Issue at pc=0x1000_0000 with J, instr[25:0]=26'h000_0010 -> next imem_addr=0x1000_0040; JAL: pc_plus4=0x1000_0004 during ISSUE.
REQ-040 jumpReg with jr_target=0x0000_0103 -> next imem_addr=0x100, pc_misalign one-cycle pulse.
REQ-041 instr_ready held low 5 cycles in ISSUE -> instr stable, imem_req=0 throughout; pc=0xFFFF_FFFC sequential -> next imem_addr=0.
REQ-042 rst_n asserted in REQ with ack pending, ack arrives during reset -> all outputs at reset values, first post-reset fetch at RESET_PC.
